// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end: fetch state encoding,
// reset/NOP constants and the opcode field position used by control.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction word and its PC+4, used to
// absorb the word that returns from memory while decode is stalled.
module fetch_skid_buffer
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc_plus4,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [ADDR_W-1:0] pc_plus4_r;

    // Entry register: flush wins over load, load wins over unload.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_r    <= 1'b0;
            data_r     <= DATA_W'(NOP_INSTR);
            pc_plus4_r <= {ADDR_W{1'b0}};
        end else if (flush) begin
            valid_r    <= 1'b0;
            data_r     <= DATA_W'(NOP_INSTR);
            pc_plus4_r <= pc_plus4_r;
        end else if (load) begin
            valid_r    <= 1'b1;
            data_r     <= load_data;
            pc_plus4_r <= load_pc_plus4;
        end else if (unload) begin
            valid_r    <= 1'b0;
            data_r     <= data_r;
            pc_plus4_r <= pc_plus4_r;
        end else begin
            valid_r    <= valid_r;
            data_r     <= data_r;
            pc_plus4_r <= pc_plus4_r;
        end
    end

    assign valid    = valid_r;
    assign data     = data_r;
    assign pc_plus4 = pc_plus4_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, req/ack instruction-memory port and
// the IF/ID output register, with skid buffering for stalls and redirect squash.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              arst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc_plus4
);

    fetch_state_e      state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] imem_addr_r, imem_addr_s;
    logic              imem_req_r, imem_req_s;
    logic              if_valid_r, if_valid_s;
    logic [DATA_W-1:0] if_instr_r, if_instr_s;
    logic [ADDR_W-1:0] if_pc_plus4_r, if_pc_plus4_s;

    logic              out_free_s;
    logic              flush_s;
    logic              skid_load_s, skid_unload_s, skid_valid_s;
    logic [DATA_W-1:0] skid_data_s;
    logic [ADDR_W-1:0] skid_pc_plus4_s;
    logic [ADDR_W-1:0] redirect_pc_s, pc_inc_s, addr_inc_s;

    assign redirect_pc_s = redirect_pc & ~ADDR_W'(2'd3);
    assign pc_inc_s      = pc_r + ADDR_W'(3'd4);
    assign addr_inc_s    = imem_addr_r + ADDR_W'(3'd4);
    assign out_free_s    = ~if_valid_r | ~stall;

    // Next-state, PC, request address and output-register update.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        imem_addr_s   = imem_addr_r;
        if_valid_s    = if_valid_r & stall;
        if_instr_s    = if_instr_r;
        if_pc_plus4_s = if_pc_plus4_r;
        flush_s       = 1'b0;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;

        case (state_r)
            IDLE: begin
                state_s = REQ;
                if (redirect) begin
                    pc_s        = redirect_pc_s;
                    imem_addr_s = redirect_pc_s;
                end else begin
                    imem_addr_s = pc_r;
                end
            end
            REQ: begin
                if (redirect) begin
                    flush_s    = 1'b1;
                    if_valid_s = 1'b0;
                    if_instr_s = DATA_W'(NOP_INSTR);
                    pc_s       = redirect_pc_s;
                    // Without an ack the old request must still be finished.
                    if (imem_ack) begin
                        imem_addr_s = redirect_pc_s;
                    end else begin
                        state_s = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_s = pc_inc_s;
                    if (out_free_s) begin
                        if_valid_s    = 1'b1;
                        if_instr_s    = imem_rdata;
                        if_pc_plus4_s = addr_inc_s;
                        imem_addr_s   = pc_inc_s;
                    end else begin
                        skid_load_s = 1'b1;
                        state_s     = FULL;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            DRAIN: begin
                flush_s = redirect;
                pc_s    = redirect ? redirect_pc_s : pc_r;
                if (imem_ack) begin
                    state_s     = REQ;
                    imem_addr_s = redirect ? redirect_pc_s : pc_r;
                end else begin
                    state_s = DRAIN;
                end
            end
            FULL: begin
                if (redirect) begin
                    flush_s     = 1'b1;
                    if_valid_s  = 1'b0;
                    if_instr_s  = DATA_W'(NOP_INSTR);
                    pc_s        = redirect_pc_s;
                    imem_addr_s = redirect_pc_s;
                    state_s     = REQ;
                end else if (!stall && skid_valid_s) begin
                    skid_unload_s = 1'b1;
                    if_valid_s    = 1'b1;
                    if_instr_s    = skid_data_s;
                    if_pc_plus4_s = skid_pc_plus4_s;
                    imem_addr_s   = pc_r;
                    state_s       = REQ;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        imem_req_s = (state_s == REQ) || (state_s == DRAIN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= RESET_PC;
            if_valid_r    <= 1'b0;
            if_instr_r    <= DATA_W'(NOP_INSTR);
            if_pc_plus4_r <= {ADDR_W{1'b0}};
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            imem_req_r    <= imem_req_s;
            imem_addr_r   <= imem_addr_s;
            if_valid_r    <= if_valid_s;
            if_instr_r    <= if_instr_s;
            if_pc_plus4_r <= if_pc_plus4_s;
        end
    end

    fetch_skid_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk           (clk),
        .arst          (arst),
        .load          (skid_load_s),
        .unload        (skid_unload_s),
        .flush         (flush_s),
        .load_data     (imem_rdata),
        .load_pc_plus4 (addr_inc_s),
        .valid         (skid_valid_s),
        .data          (skid_data_s),
        .pc_plus4      (skid_pc_plus4_s)
    );

    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign if_valid    = if_valid_r;
    assign if_instr    = if_instr_r;
    assign if_pc_plus4 = if_pc_plus4_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model with configurable wait states,
// program-order scoreboard, directed scenarios and a randomized run.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        arst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc_plus4 (if_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] salt = 32'h0;
    logic [31:0] gen_pc = 32'h0;
    logic [31:0] req_addr = 32'h0;
    int          wait_fixed = 0;
    int          remaining = 0;
    bit          busy = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every word decode accepts must be the next one in program order.
    always @(negedge clk) begin
        if (!arst && if_valid && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got %h, want no instruction", if_instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_instr", if_instr, mon_e.instr);
                check("sb_pc4", if_pc_plus4, mon_e.pc4);
            end
        end
    end

    task automatic mem_step();
        if (arst) begin
            busy     = 1'b0;
            imem_ack = 1'b0;
        end else if (!imem_req) begin
            if (busy) begin
                checks++;
                errors++;
                $display("FAIL req_hold: got imem_req=0, want 1 until ack");
            end
            busy     = 1'b0;
            imem_ack = 1'b0;
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                req_addr  = imem_addr;
                remaining = (wait_fixed < 0) ? int'($urandom_range(0, 3)) : wait_fixed;
            end else begin
                check("addr_hold", imem_addr, req_addr);
            end
            if (remaining == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                busy       = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                remaining--;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
        exp_t e;
        @(posedge clk);
        #1;
        if (redirect) begin
            exp_q.delete();
            gen_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        while (exp_q.size() < 4) begin
            e.instr = mem_word(gen_pc);
            e.pc4   = gen_pc + 32'd4;
            exp_q.push_back(e);
            gen_pc  = gen_pc + 32'd4;
        end
        mem_step();
        stall       = st;
        redirect    = rd;
        redirect_pc = rd ? rpc : $urandom;
    endtask

    task automatic do_reset(input logic [31:0] s, input int w);
        arst        = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        @(posedge clk);
        #1;
        salt       = s;
        wait_fixed = w;
        busy       = 1'b0;
        exp_q.delete();
        gen_pc     = 32'h0;
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    initial begin
        arst        = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc4", if_pc_plus4, 32'h0);

        // Zero-wait stream, data equals address.
        do_reset(32'h0, 0);
        check("idle_req", 32'(imem_req), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("seq_req", 32'(imem_req), 32'd1);
            check("seq_addr", imem_addr, 32'(4 * (k - 1)));
            if (k >= 2) begin
                check("seq_valid", 32'(if_valid), 32'd1);
                check("seq_instr", if_instr, 32'(4 * (k - 2)));
                check("seq_pc4", if_pc_plus4, 32'(4 * (k - 1)));
            end
        end

        // Three wait states: one instruction every four cycles.
        do_reset(32'h0, 3);
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("ws_addr", imem_addr, 32'(4 * ((k - 1) / 4)));
            check("ws_valid", 32'(if_valid), (k >= 5 && (k - 1) % 4 == 0) ? 32'd1 : 32'd0);
        end

        // Three-cycle stall into the skid buffer.
        do_reset(32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("full_req_drop", 32'(imem_req), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        check("full_req_low", 32'(imem_req), 32'd0);
        check("full_hold_instr", if_instr, 32'h4);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("skid_instr", if_instr, 32'h8);
        check("skid_pc4", if_pc_plus4, 32'hC);
        check("skid_next_addr", imem_addr, 32'hC);
        check("skid_req", 32'(imem_req), 32'd1);
        repeat (6) cycle(1'b0, 1'b0, 32'h0);

        // Redirect while a two-wait request to 0x8 is outstanding.
        do_reset(32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        wait_fixed = 2;
        cycle(1'b0, 1'b1, 32'h100);
        for (int k = 4; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("drain_valid", 32'(if_valid), 32'd0);
            check("drain_addr", imem_addr, (k == 6) ? 32'h100 : 32'h8);
        end
        wait_fixed = 0;
        repeat (8) cycle(1'b0, 1'b0, 32'h0);

        // Redirect while FULL and stalled.
        do_reset(32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h40);
        cycle(1'b0, 1'b0, 32'h0);
        check("fullredir_valid", 32'(if_valid), 32'd0);
        check("fullredir_addr", imem_addr, 32'h40);
        check("fullredir_req", 32'(imem_req), 32'd1);
        repeat (6) cycle(1'b0, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        do_reset(32'h00FF_0000, 0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0);
        check("wrap_pc4", if_pc_plus4, 32'h0);
        check("wrap_instr", if_instr, 32'hFFFF_FFFC ^ 32'h00FF_0000);
        repeat (4) cycle(1'b0, 1'b0, 32'h0);

        // Asynchronous reset in the middle of DRAIN.
        do_reset(32'h1234_0000, 0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        wait_fixed = 3;
        cycle(1'b0, 1'b1, 32'h80);
        cycle(1'b0, 1'b0, 32'h0);
        check("pre_arst_req", 32'(imem_req), 32'd1);
        check("pre_arst_addr", imem_addr, 32'hC);
        #3;
        arst = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", 32'(if_valid), 32'd0);
        check("arst_instr", if_instr, 32'h0);
        check("arst_pc4", if_pc_plus4, 32'h0);

        // Randomized stalls, redirects and wait states.
        do_reset($urandom, -1);
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom);
        end
        repeat (20) cycle(1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
